// File: rtl/opo_package.sv
// Shared types and default widths for the filter sweep controller and the
// blocks that reuse its peak tracker.
package opo_package;

  localparam int WORD_WIDTH_DEF     = 16;
  localparam int PERIOD_WIDTH_DEF   = 32;
  localparam int CYCLE_WIDTH_DEF    = 32;
  localparam int DUT_RST_CYCLES_DEF = 16;

  typedef enum logic [15:0] {
    IDLE    = 16'd0,
    DUT_RST = 16'd1,
    SETTLE  = 16'd2,
    MEASURE = 16'd3,
    REPORT  = 16'd4,
    FINISH  = 16'd5
  } state_e;

endpackage

// File: rtl/peak_tracker.sv
// Signed running min/max over a window.
//   clear_i  : restart the window (max -> most negative, min -> most positive)
//   valid_i  : sample_i qualifier
//   max_o/min_o : extremes seen since the last clear
//   seen_o   : at least one valid sample since the last clear
module peak_tracker #(
  parameter int word_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [word_width-1:0] sample_i,
  output logic [word_width-1:0] max_o,
  output logic [word_width-1:0] min_o,
  output logic                  seen_o
);

  localparam logic [word_width-1:0] MOST_NEG = {1'b1, {(word_width-1){1'b0}}};
  localparam logic [word_width-1:0] MOST_POS = {1'b0, {(word_width-1){1'b1}}};

  logic [word_width-1:0] max_q, min_q;
  logic                  seen_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q  <= MOST_NEG;
      min_q  <= MOST_POS;
      seen_q <= 1'b0;
    end else if (clear_i) begin
      max_q  <= MOST_NEG;
      min_q  <= MOST_POS;
      seen_q <= 1'b0;
    end else if (valid_i) begin
      if ($signed(sample_i) > $signed(max_q)) max_q <= sample_i;
      if ($signed(sample_i) < $signed(min_q)) min_q <= sample_i;
      seen_q <= 1'b1;
    end
  end

  assign max_o  = max_q;
  assign min_o  = min_q;
  assign seen_o = seen_q;

endmodule

// File: rtl/filter_sweep_controller.sv
// Steps the sine_gen period from period_start to period_stop. For each point:
// hold the filter chain in reset, let it settle, track the output peak-to-peak
// over a window, then offer one result record on a valid/ready handshake.
//   start/abort       : sweep control pulses
//   period_*          : sweep range and step (latched on start)
//   settle/measure    : per-point timing (latched on start)
//   sample_in/valid   : filter output under test
//   period_out/dut_rst: drive sine_gen and the filter chain
//   res_*             : result record, res_valid/res_ready handshake
//   busy/done         : sweep status
module filter_sweep_controller
  import opo_package::*;
#(
  parameter int word_width     = WORD_WIDTH_DEF,
  parameter int period_width   = PERIOD_WIDTH_DEF,
  parameter int cycle_width    = CYCLE_WIDTH_DEF,
  parameter int dut_rst_cycles = DUT_RST_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [period_width-1:0] period_start,
  input  logic [period_width-1:0] period_step,
  input  logic [period_width-1:0] period_stop,
  input  logic [cycle_width-1:0]  settle_cycles,
  input  logic [cycle_width-1:0]  measure_cycles,
  input  logic [word_width-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [period_width-1:0] period_out,
  output logic                    dut_rst,
  output logic [period_width-1:0] res_period,
  output logic [word_width-1:0]   res_max,
  output logic [word_width-1:0]   res_min,
  output logic [word_width:0]     res_p2p,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [cycle_width-1:0]  RST_LAST = cycle_width'(dut_rst_cycles - 1);
  localparam logic [cycle_width-1:0]  ONE_C    = cycle_width'(1);
  localparam logic [period_width-1:0] ONE_P    = period_width'(1);

  state_e                  state_q, state_d;
  logic [cycle_width-1:0]  cnt_q, cnt_d, settle_q, settle_d, meas_q, meas_d;
  logic [period_width-1:0] period_q, period_d, step_q, step_d, stop_q, stop_d;
  logic [period_width-1:0] res_period_q, res_period_d;
  logic [word_width-1:0]   res_max_q, res_max_d, res_min_q, res_min_d;
  logic [word_width:0]     res_p2p_q, res_p2p_d;
  logic                    res_valid_q, res_valid_d;

  logic [period_width-1:0] step_eff;
  logic [cycle_width-1:0]  meas_eff;
  logic [period_width:0]   next_sum;
  logic [word_width-1:0]   trk_max, trk_min;
  logic                    trk_seen;

  assign step_eff = (step_q == '0) ? ONE_P : step_q;
  assign meas_eff = (meas_q == '0) ? ONE_C : meas_q;
  // One extra bit so a wrap past the top of the period range ends the sweep.
  assign next_sum = {1'b0, period_q} + {1'b0, step_eff};

  // The window is re-armed while the filter is held/settling, so MEASURE
  // always starts from a clean tracker.
  peak_tracker #(.word_width(word_width)) u_peak (
    .clk      (clk),
    .rst      (rst),
    .clear_i  ((state_q == DUT_RST) || (state_q == SETTLE)),
    .valid_i  (sample_valid && (state_q == MEASURE)),
    .sample_i (sample_in),
    .max_o    (trk_max),
    .min_o    (trk_min),
    .seen_o   (trk_seen)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    meas_d       = meas_q;
    period_d     = period_q;
    step_d       = step_q;
    stop_d       = stop_q;
    res_period_d = res_period_q;
    res_max_d    = res_max_q;
    res_min_d    = res_min_q;
    res_p2p_d    = res_p2p_q;
    res_valid_d  = res_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          period_d = period_start;
          step_d   = period_step;
          stop_d   = period_stop;
          settle_d = settle_cycles;
          meas_d   = measure_cycles;
          cnt_d    = '0;
          state_d  = DUT_RST;
        end
      end
      DUT_RST: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = (settle_q == '0) ? MEASURE : SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == settle_q - ONE_C) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == meas_eff - ONE_C) begin
          cnt_d   = '0;
          state_d = REPORT;
        end
      end
      REPORT: begin
        // First REPORT cycle captures the window; valid rises after it.
        if (!res_valid_q) begin
          res_period_d = period_q;
          res_valid_d  = 1'b1;
          if (trk_seen) begin
            res_max_d = trk_max;
            res_min_d = trk_min;
            res_p2p_d = {trk_max[word_width-1], trk_max} - {trk_min[word_width-1], trk_min};
          end else begin
            res_max_d = '0;
            res_min_d = '0;
            res_p2p_d = '0;
          end
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = '0;
          if (next_sum[period_width] || (next_sum[period_width-1:0] > stop_q)) begin
            state_d = FINISH;
          end else begin
            period_d = next_sum[period_width-1:0];
            state_d  = DUT_RST;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a handshake in the same cycle.
    if (abort && (state_q != IDLE) && (state_q != FINISH)) begin
      state_d     = FINISH;
      res_valid_d = 1'b0;
      period_d    = period_q;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      settle_q     <= '0;
      meas_q       <= '0;
      period_q     <= '0;
      step_q       <= '0;
      stop_q       <= '0;
      res_period_q <= '0;
      res_max_q    <= '0;
      res_min_q    <= '0;
      res_p2p_q    <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      meas_q       <= meas_d;
      period_q     <= period_d;
      step_q       <= step_d;
      stop_q       <= stop_d;
      res_period_q <= res_period_d;
      res_max_q    <= res_max_d;
      res_min_q    <= res_min_d;
      res_p2p_q    <= res_p2p_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign period_out = period_q;
  assign dut_rst    = (state_q == SETTLE) || (state_q == MEASURE) || (state_q == REPORT);
  assign res_period = res_period_q;
  assign res_max    = res_max_q;
  assign res_min    = res_min_q;
  assign res_p2p    = res_p2p_q;
  // Abort withdraws a pending result in the same cycle.
  assign res_valid  = res_valid_q & ~abort;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);

endmodule
